key_conditioner: RTL and testbench
==================================

# key_conditioner

Input-conditioning stage placed directly upstream of the combination-lock FSM. It synchronises the raw active-low ENTER push-button and the slide switches to `clk`, then debounces the button. It emits exactly one single-cycle active-high `ENTER` pulse per debounced press, and the synchronised switch bus supplies the lock's `MATCH` source.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: number of consecutive stable `clk` cycles required to accept a level change (20 ms at 50 MHz). Must be ≥ 1.
- `SW_W`, default 10: width of the switch bus.

- `clk`, in, 1: system clock (50 MHz board clock); all state changes on the rising edge.
- `RESETN`, in, 1: reset, asynchronous and active-low.
- `KEY_N`, in, 1: raw push-button, active-low (0 = pressed), asynchronous to `clk`.
- `SW_RAW`, in, `SW_W`: raw slide switches, asynchronous.
- `ENTER`, out, 1: registered one-cycle pulse per accepted press.
- `HELD`, out, 1: registered debounced button level (1 = pressed).
- `SW_SYNC`, out, `SW_W`: switches after a 2-FF synchroniser.

## Operation
- Synchronisers:
  - `KEY_N` passes through 2 flops that reset to 1 (released); call the second flop `k`.
  - `SW_RAW` passes through 2 flops per bit that reset to 0; the second stage drives `SW_SYNC`.
- Debounce counter `cnt`: width `$clog2(DEBOUNCE_CYCLES)`, minimum 1; unsigned; it never wraps because it is cleared before reaching `DEBOUNCE_CYCLES`.
- FSM states and transitions:
  - RELEASED:
    - `k`=0 → PRESS_WAIT, `cnt`←0.
    - Otherwise stay.
  - PRESS_WAIT:
    - `k`=1 → RELEASED (glitch rejected, no pulse).
    - `k`=0 and `cnt`==`DEBOUNCE_CYCLES`-1 → PRESSED.
    - `k`=0 otherwise → `cnt`++.
  - PRESSED:
    - `k`=1 → RELEASE_WAIT, `cnt`←0.
    - Otherwise stay.
  - RELEASE_WAIT:
    - `k`=0 → PRESSED (release bounce rejected, no new pulse).
    - `k`=1 and `cnt`==`DEBOUNCE_CYCLES`-1 → RELEASED.
    - `k`=1 otherwise → `cnt`++.
- Outputs (Moore, registered):
  - `HELD`=1 in PRESSED and RELEASE_WAIT, 0 otherwise.
  - `ENTER`=1 only in the first cycle after the PRESS_WAIT→PRESSED transition.
  - The RELEASE_WAIT→PRESSED transition never pulses `ENTER`.
- A button held indefinitely yields one `ENTER` only. The next pulse requires a full debounced release followed by a full debounced press.

## Timing
- Reset: while `RESETN`=0, and immediately on its assertion (asynchronous):
  - `ENTER`=0, `HELD`=0, `SW_SYNC`=0.
  - State RELEASED, `cnt`=0, key synchroniser flops = 1.
- Reset mid-operation:
  - Any press or release in progress is discarded.
  - After reset release, a button still held low is treated as a new press: it produces exactly one `ENTER` after the full latency below.
- Press latency: let e0 be the first rising edge sampling `KEY_N`=0, with `KEY_N` held low afterwards.
  - `k`=0 after e1; PRESS_WAIT entered at e2.
  - PRESSED entered at edge e0+`DEBOUNCE_CYCLES`+2.
  - `ENTER` and `HELD` rise at that edge; `ENTER` falls at the next edge.
- Release latency: same structure. The first edge sampling `KEY_N`=1 is r0; `HELD` falls at edge r0+`DEBOUNCE_CYCLES`+2.
- Glitch rule: a low pulse on `KEY_N` is ignored if its sampled width is ≤ `DEBOUNCE_CYCLES` cycles (with `DEBOUNCE_CYCLES`=4, 3 samples are ignored).
- `SW_SYNC` latency: exactly 2 edges; no debounce on switches.
- `ENTER` is never high for 2 consecutive cycles.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `SW_W`=10.
- Reset: drive `RESETN`=0 with `KEY_N`=0, `SW_RAW`=10'h3FF → `ENTER`=0, `HELD`=0, `SW_SYNC`=0 asynchronously, held for the whole reset.
- Clean press: `KEY_N` 1→0 sampled first at e0, held 20 cycles → `ENTER`=1 exactly in the cycle after e6; `HELD`=1 from e6; no further `ENTER`.
- Press bounce: `KEY_N` low for 3 sampled edges, then high → `ENTER` stays 0, `HELD` stays 0. Then a clean 20-cycle low → exactly one `ENTER`.
- Release bounce:
  - From PRESSED, drive `KEY_N` high 2 cycles, then low 5 → `HELD` stays 1, no `ENTER`.
  - Then `KEY_N` high from r0 → `HELD` falls at r0+6.
- Switch sync: `SW_RAW`=10'h2A5 applied before edge s0 → `SW_SYNC`=10'h2A5 after s1, and still 0 after s0.
- Reset mid-press: assert `RESETN`=0 while `HELD`=1 → `HELD`/`ENTER` go 0 immediately. Release `RESETN` with `KEY_N` still low → exactly one `ENTER`, 6 edges after the first post-reset edge.

Source files
------------

// File: rtl/key_conditioner.sv
// ---------------------------------------------------------------------------
// key_conditioner
//
// Purpose:
//   This is the input conditioning stage that sits in front of the
//   combination-lock FSM.
//   - The raw active-low ENTER push-button goes through a 2-flop
//     synchroniser into the clk domain and is then debounced.
//   - Each debounced press produces exactly one single-cycle ENTER pulse.
//   - The slide switches go through a 2-flop synchroniser only, with no
//     debounce. The result feeds the lock's MATCH comparison.
//
// Parameters:
//   DEBOUNCE_CYCLES : number of consecutive stable clk cycles needed to
//                     accept a level change on the button (must be >= 1)
//   SW_W            : width of the switch bus
//
// Ports:
//   clk     in   1     system clock, rising-edge active
//   RESETN  in   1     asynchronous active-low reset
//   KEY_N   in   1     raw push-button, 0 = pressed, asynchronous to clk
//   SW_RAW  in   SW_W  raw slide switches, asynchronous to clk
//   ENTER   out  1     registered one-cycle pulse per accepted press
//   HELD    out  1     registered debounced button level, 1 = pressed
//   SW_SYNC out  SW_W  switches after the 2-flop synchroniser
// ---------------------------------------------------------------------------
module key_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int SW_W            = 10
) (
   input  logic            clk,
   input  logic            RESETN,
   input  logic            KEY_N,
   input  logic [SW_W-1:0] SW_RAW,
   output logic            ENTER,
   output logic            HELD,
   output logic [SW_W-1:0] SW_SYNC
);

   // The counter only has to reach DEBOUNCE_CYCLES-1, because it is cleared
   // before it could ever reach DEBOUNCE_CYCLES. With DEBOUNCE_CYCLES == 1,
   // $clog2 returns 0, so the width is clamped to at least one bit.
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } keyState_t;

   logic            keyMeta_q;
   logic            keySync_q;
   logic [SW_W-1:0] swMeta_q;
   logic [SW_W-1:0] swSync_q;

   keyState_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic            enter_q;
   logic            held_q;

   // Key synchroniser.
   // Both flops reset to 1, the "released" level. This means that coming
   // out of reset, a button that is still held down looks like a fresh
   // press and must go through the full debounce again.
   // keySync_q is the synchronised key level that the FSM works on.
   always_ff @(posedge clk or negedge RESETN) begin
      if (!RESETN) begin
         keyMeta_q <= 1'b1;
         keySync_q <= 1'b1;
      end else begin
         keyMeta_q <= KEY_N;
         keySync_q <= keyMeta_q;
      end
   end

   // Switch synchroniser.
   // This is a plain two-stage synchroniser per bit. The switches are
   // slow-moving levels, and the lock only compares them when ENTER
   // fires, so no debounce is applied here.
   always_ff @(posedge clk or negedge RESETN) begin
      if (!RESETN) begin
         swMeta_q <= '0;
         swSync_q <= '0;
      end else begin
         swMeta_q <= SW_RAW;
         swSync_q <= swMeta_q;
      end
   end

   // Debounce FSM.
   // A level change on the synchronised key is accepted only after it has
   // been stable for DEBOUNCE_CYCLES cycles in one of the WAIT states.
   // Any reversal during a WAIT state returns the FSM to the stable state
   // it came from.
   //
   // HELD and ENTER are registered here together with the state:
   // - HELD follows the stable level.
   // - ENTER is set only on the PRESS_WAIT -> PRESSED transition and is
   //   cleared by default on every other edge. It can therefore never be
   //   high for two consecutive cycles.
   // A bounce during release (RELEASE_WAIT -> PRESSED) deliberately does
   // not set ENTER, so a button held down yields one pulse only.
   always_ff @(posedge clk or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= RELEASED;
         cnt_q   <= '0;
         enter_q <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         enter_q <= 1'b0;
         unique case (state_q)
            RELEASED: begin
               if (!keySync_q) begin
                  state_q <= PRESS_WAIT;
                  cnt_q   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (keySync_q) begin
                  state_q <= RELEASED;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= PRESSED;
                  enter_q <= 1'b1;
                  held_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            PRESSED: begin
               if (keySync_q) begin
                  state_q <= RELEASE_WAIT;
                  cnt_q   <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (!keySync_q) begin
                  state_q <= PRESSED;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= RELEASED;
                  held_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= RELEASED;
               cnt_q   <= '0;
               held_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ENTER   = enter_q;
   assign HELD    = held_q;
   assign SW_SYNC = swSync_q;

endmodule

// File: tb/tb_key_conditioner.sv
// ---------------------------------------------------------------------------
// tb_key_conditioner
//
// Purpose:
//   Directed testbench for key_conditioner, run with DEBOUNCE_CYCLES = 4 and
//   SW_W = 10.
//   - Inputs are driven 1 time unit after each rising edge.
//   - Outputs are sampled at that same point.
//   - After the n-th edge that samples a new KEY_N level (edge index n-1
//     below), the expected outputs follow from the press/release latency of
//     DEBOUNCE_CYCLES + 2 edges, i.e. 6 edges here.
// ---------------------------------------------------------------------------
module tb_key_conditioner;

   localparam int DEB  = 4;
   localparam int SWW  = 10;
   localparam int LAT  = DEB + 2;

   logic           clk;
   logic           RESETN;
   logic           KEY_N;
   logic [SWW-1:0] SW_RAW;
   logic           ENTER;
   logic           HELD;
   logic [SWW-1:0] SW_SYNC;

   int compared;
   int mismatched;

   key_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .SW_W           (SWW)
   ) dut (
      .clk    (clk),
      .RESETN (RESETN),
      .KEY_N  (KEY_N),
      .SW_RAW (SW_RAW),
      .ENTER  (ENTER),
      .HELD   (HELD),
      .SW_SYNC(SW_SYNC)
   );

   // 10-time-unit clock with the first rising edge at t=5.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance past the next rising edge to the drive/sample point.
   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   // Assert reset asynchronously, mid-cycle, with the key pressed and all
   // switches set. The outputs must clear immediately and stay clear for
   // the whole time reset is held.
   task automatic test_reset();
      RESETN = 1'b1;
      KEY_N  = 1'b1;
      SW_RAW = '0;
      #2;
      RESETN = 1'b0;
      KEY_N  = 1'b0;
      SW_RAW = 10'h3FF;
      #1;
      compared++;
      if (ENTER !== 1'b0 || HELD !== 1'b0 || SW_SYNC !== 10'h000) begin
         mismatched++;
         $display("[TB] FAIL reset_async: ENTER=%b HELD=%b SW_SYNC=%h, required 0 0 000",
                  ENTER, HELD, SW_SYNC);
      end
      for (int i = 0; i < 5; i++) begin
         stepClock();
         compared++;
         if (ENTER !== 1'b0 || HELD !== 1'b0 || SW_SYNC !== 10'h000) begin
            mismatched++;
            $display("[TB] FAIL reset_hold cycle %0d: ENTER=%b HELD=%b SW_SYNC=%h, required 0 0 000",
                     i, ENTER, HELD, SW_SYNC);
         end
      end
      KEY_N  = 1'b1;
      SW_RAW = '0;
      RESETN = 1'b1;
      for (int i = 0; i < 4; i++) stepClock();
   endtask

   // Hold the key low for 20 sampled edges. ENTER must appear only after
   // e6, and HELD must be high from e6 onward.
   task automatic test_clean_press(input string tag);
      int pulses;
      logic expHeld, expEnter;
      pulses = 0;
      KEY_N = 1'b0;
      for (int i = 0; i < 20; i++) begin
         stepClock();
         expHeld  = (i >= LAT);
         expEnter = (i == LAT);
         if (ENTER === 1'b1) pulses++;
         compared++;
         if (HELD !== expHeld || ENTER !== expEnter) begin
            mismatched++;
            $display("[TB] FAIL %s after e%0d: HELD=%b ENTER=%b, required %b %b",
                     tag, i, HELD, ENTER, expHeld, expEnter);
         end
      end
      compared++;
      if (pulses !== 1) begin
         mismatched++;
         $display("[TB] FAIL %s_pulse_count: got %0d, required 1", tag, pulses);
      end
   endtask

   // Release from PRESSED starting at edge r0. HELD must fall at r0+6 and
   // ENTER must stay low throughout.
   task automatic test_release(input string tag);
      logic expHeld;
      KEY_N = 1'b1;
      for (int i = 0; i < 10; i++) begin
         stepClock();
         expHeld = (i < LAT);
         compared++;
         if (HELD !== expHeld || ENTER !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL %s after r%0d: HELD=%b ENTER=%b, required %b 0",
                     tag, i, HELD, ENTER, expHeld);
         end
      end
   endtask

   // A 3-sample low glitch must be rejected completely. A clean press
   // afterwards must then yield exactly one ENTER.
   task automatic test_press_bounce();
      KEY_N = 1'b0;
      for (int i = 0; i < 13; i++) begin
         if (i == 3) KEY_N = 1'b1;
         stepClock();
         compared++;
         if (HELD !== 1'b0 || ENTER !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL press_bounce cycle %0d: HELD=%b ENTER=%b, required 0 0",
                     i, HELD, ENTER);
         end
      end
      test_clean_press("bounce_then_press");
   endtask

   // Starting from PRESSED: drive the key high for 2 cycles, then low for
   // 5. HELD must stay 1 with no new ENTER. A clean release after that
   // must drop HELD at r0+6.
   task automatic test_release_bounce();
      KEY_N = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 2) KEY_N = 1'b0;
         stepClock();
         compared++;
         if (HELD !== 1'b1 || ENTER !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL release_bounce cycle %0d: HELD=%b ENTER=%b, required 1 0",
                     i, HELD, ENTER);
         end
      end
      test_release("release_after_bounce");
   endtask

   // A switch value applied before edge s0 must still read 0 after s0 and
   // must appear on SW_SYNC after s1.
   task automatic test_switch_sync();
      logic [SWW-1:0] vals [2];
      logic [SWW-1:0] prev;
      vals[0] = 10'h2A5;
      vals[1] = 10'h15A;
      prev    = 10'h000;
      for (int v = 0; v < 2; v++) begin
         SW_RAW = vals[v];
         stepClock();
         compared++;
         if (SW_SYNC !== prev) begin
            mismatched++;
            $display("[TB] FAIL sw_sync_s0 value %0d: SW_SYNC=%h, required %h", v, SW_SYNC, prev);
         end
         stepClock();
         compared++;
         if (SW_SYNC !== vals[v]) begin
            mismatched++;
            $display("[TB] FAIL sw_sync_s1 value %0d: SW_SYNC=%h, required %h", v, SW_SYNC, vals[v]);
         end
         prev = vals[v];
      end
   endtask

   // Reset while HELD is high clears the outputs immediately. Releasing
   // reset with the key still low counts as a new press, with its ENTER
   // coming 6 edges after the first post-reset edge.
   task automatic test_reset_mid_press();
      logic expHeld, expEnter;
      int pulses;
      KEY_N = 1'b0;
      for (int i = 0; i < 10; i++) stepClock();
      compared++;
      if (HELD !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL mid_press_setup: HELD=%b, required 1", HELD);
      end
      RESETN = 1'b0;
      #1;
      compared++;
      if (HELD !== 1'b0 || ENTER !== 1'b0 || SW_SYNC !== 10'h000) begin
         mismatched++;
         $display("[TB] FAIL mid_press_reset: HELD=%b ENTER=%b SW_SYNC=%h, required 0 0 000",
                  HELD, ENTER, SW_SYNC);
      end
      stepClock();
      stepClock();
      RESETN = 1'b1;
      pulses = 0;
      for (int i = 0; i < 14; i++) begin
         stepClock();
         expHeld  = (i >= LAT);
         expEnter = (i == LAT);
         if (ENTER === 1'b1) pulses++;
         compared++;
         if (HELD !== expHeld || ENTER !== expEnter) begin
            mismatched++;
            $display("[TB] FAIL post_reset_press after p%0d: HELD=%b ENTER=%b, required %b %b",
                     i, HELD, ENTER, expHeld, expEnter);
         end
      end
      compared++;
      if (pulses !== 1) begin
         mismatched++;
         $display("[TB] FAIL post_reset_pulse_count: got %0d, required 1", pulses);
      end
   endtask

   // Run the scenarios in order, then print the summary line.
   initial begin
      compared   = 0;
      mismatched = 0;
      RESETN     = 1'b1;
      KEY_N      = 1'b1;
      SW_RAW     = '0;
      test_reset();
      test_clean_press("clean_press");
      test_release("clean_release");
      test_press_bounce();
      test_release_bounce();
      test_switch_sync();
      test_reset_mid_press();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
